// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: command channel, write-back port and ALU operand channel.
// The stage takes the slave modport; whoever drives commands and consumes operands takes master.
interface alu_operand_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [REG_AW-1:0] cmd_rn;
  logic [REG_AW-1:0] cmd_rm;
  logic [1:0]        cmd_shift;
  logic              cmd_asel;
  logic              cmd_bsel;
  logic [IMM_W-1:0]  cmd_imm;
  logic [1:0]        cmd_aluop;
  logic              wb_en;
  logic [REG_AW-1:0] wb_num;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] Ain;
  logic [DATA_W-1:0] Bin;
  logic [1:0]        ALUop;
  logic              op_valid;
  logic              op_ready;

  modport master (
    output cmd_valid, cmd_rn, cmd_rm, cmd_shift, cmd_asel, cmd_bsel, cmd_imm, cmd_aluop,
    output wb_en, wb_num, wb_data, op_ready,
    input  cmd_ready, Ain, Bin, ALUop, op_valid
  );

  modport slave (
    input  cmd_valid, cmd_rn, cmd_rm, cmd_shift, cmd_asel, cmd_bsel, cmd_imm, cmd_aluop,
    input  wb_en, wb_num, wb_data, op_ready,
    output cmd_ready, Ain, Bin, ALUop, op_valid
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: 8-entry register file, two-cycle A/B read,
// B shifter and source selects, registered operands presented with valid/ready.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  io
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_ISSUE  = 2'd3;

  function automatic logic [DATA_W-1:0] shift_b(input logic [1:0] sh, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (sh)
      2'b00:   r = v;
      2'b01:   r = {v[DATA_W-2:0], 1'b0};
      2'b10:   r = {1'b0, v[DATA_W-1:1]};
      2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [REG_AW-1:0] rn_q, rn_d, rm_q, rm_d;
  logic [1:0]        shift_q, shift_d, aluop_q, aluop_d;
  logic              asel_q, asel_d, bsel_q, bsel_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] ain_q, ain_d, bin_q, bin_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              op_valid_q, op_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0] rd_a_s, rd_b_s;

  // Register-file write port, active in every state
  always_comb begin
    rf_d = rf_q;
    if (io.wb_en) begin
      rf_d[io.wb_num] = io.wb_data;
    end else begin
      rf_d = rf_q;
    end
  end

  // Read ports with write-through bypass so a same-cycle write is never missed
  always_comb begin
    rd_a_s = rf_q[rn_q];
    rd_b_s = rf_q[rm_q];
    if (io.wb_en && (io.wb_num == rn_q)) begin
      rd_a_s = io.wb_data;
    end else begin
      rd_a_s = rf_q[rn_q];
    end
    if (io.wb_en && (io.wb_num == rm_q)) begin
      rd_b_s = io.wb_data;
    end else begin
      rd_b_s = rf_q[rm_q];
    end
  end

  // FSM next-state, command latch, operand fetch and output formation
  always_comb begin
    state_d  = state_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shift_d  = shift_q;
    asel_d   = asel_q;
    bsel_d   = bsel_q;
    imm_d    = imm_q;
    aluop_d  = aluop_q;
    a_d      = a_q;
    b_d      = b_q;
    ain_d    = ain_q;
    bin_d    = bin_q;
    alu_op_d = alu_op_q;
    case (state_q)
      S_IDLE: begin
        if (io.cmd_valid) begin
          rn_d    = io.cmd_rn;
          rm_d    = io.cmd_rm;
          shift_d = io.cmd_shift;
          asel_d  = io.cmd_asel;
          bsel_d  = io.cmd_bsel;
          imm_d   = io.cmd_imm;
          aluop_d = io.cmd_aluop;
          state_d = S_LOAD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        a_d     = rd_a_s;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        // Outputs are formed from the B value being loaded on this same edge
        b_d      = rd_b_s;
        ain_d    = asel_q ? {DATA_W{1'b0}} : a_q;
        bin_d    = bsel_q ? sext_imm(imm_q) : shift_b(shift_q, rd_b_s);
        alu_op_d = aluop_q;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (io.op_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    op_valid_d  = (state_d == S_ISSUE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State, register file and output registers; reset aborts any command and pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
      rn_q        <= {REG_AW{1'b0}};
      rm_q        <= {REG_AW{1'b0}};
      shift_q     <= 2'b00;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      imm_q       <= {IMM_W{1'b0}};
      aluop_q     <= 2'b00;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      ain_q       <= {DATA_W{1'b0}};
      bin_q       <= {DATA_W{1'b0}};
      alu_op_q    <= 2'b00;
      op_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      shift_q     <= shift_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      imm_q       <= imm_d;
      aluop_q     <= aluop_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      alu_op_q    <= alu_op_d;
      op_valid_q  <= op_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign io.cmd_ready = cmd_ready_q;
  assign io.op_valid  = op_valid_q;
  assign io.Ain       = ain_q;
  assign io.Bin       = bin_q;
  assign io.ALUop     = alu_op_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed operand vectors, stall, bypass and reset abort.
module tb_alu_operand_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_operand_stage_if #(.DATA_W(16), .REG_AW(3), .IMM_W(5)) bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] num, input logic [15:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_num  = num;
    bus.wb_data = data;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  // Present a command in IDLE; returns just after the accepting edge (stage in LOAD_A)
  task automatic issue_cmd(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                           input logic asel, input logic bsel, input logic [4:0] imm,
                           input logic [1:0] op);
    bus.cmd_rn    = rn;
    bus.cmd_rm    = rm;
    bus.cmd_shift = sh;
    bus.cmd_asel  = asel;
    bus.cmd_bsel  = bsel;
    bus.cmd_imm   = imm;
    bus.cmd_aluop = op;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Full command with op_ready high throughout (ignored until op_valid)
  task automatic run_cmd(input string tag, input logic [2:0] rn, input logic [2:0] rm,
                         input logic [1:0] sh, input logic asel, input logic bsel,
                         input logic [4:0] imm, input logic [1:0] op,
                         input logic [15:0] ea, input logic [15:0] eb);
    bus.op_ready = 1'b1;
    issue_cmd(rn, rm, sh, asel, bsel, imm, op);
    check({tag, " valid@T+1"}, {15'd0, bus.op_valid}, 16'd0);
    check({tag, " ready@T+1"}, {15'd0, bus.cmd_ready}, 16'd0);
    tick();
    check({tag, " valid@T+2"}, {15'd0, bus.op_valid}, 16'd0);
    tick();
    check({tag, " valid@T+3"}, {15'd0, bus.op_valid}, 16'd1);
    check({tag, " Ain"}, bus.Ain, ea);
    check({tag, " Bin"}, bus.Bin, eb);
    check({tag, " ALUop"}, {14'd0, bus.ALUop}, {14'd0, op});
    tick();
    check({tag, " valid_drop"}, {15'd0, bus.op_valid}, 16'd0);
    check({tag, " ready_back"}, {15'd0, bus.cmd_ready}, 16'd1);
    bus.op_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rn = 3'd0;
    bus.cmd_rm = 3'd0;
    bus.cmd_shift = 2'b00;
    bus.cmd_asel = 1'b0;
    bus.cmd_bsel = 1'b0;
    bus.cmd_imm = 5'd0;
    bus.cmd_aluop = 2'b00;
    bus.wb_en = 1'b0;
    bus.wb_num = 3'd0;
    bus.wb_data = 16'd0;
    bus.op_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    check("reset op_valid", {15'd0, bus.op_valid}, 16'd0);
    check("reset Ain", bus.Ain, 16'h0000);
    check("reset Bin", bus.Bin, 16'h0000);
    check("reset ALUop", {14'd0, bus.ALUop}, 16'd0);

    // 1: plain read
    wr(3'd1, 16'h0007);
    wr(3'd2, 16'h0003);
    run_cmd("t1", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 16'h0007, 16'h0003);

    // 2: shifter on 0x8001
    wr(3'd2, 16'h8001);
    run_cmd("t2 lsl", 3'd1, 3'd2, 2'b01, 1'b0, 1'b0, 5'd0, 2'b01, 16'h0007, 16'h0002);
    run_cmd("t2 lsr", 3'd1, 3'd2, 2'b10, 1'b0, 1'b0, 5'd0, 2'b10, 16'h0007, 16'h4000);
    run_cmd("t2 asr", 3'd1, 3'd2, 2'b11, 1'b0, 1'b0, 5'd0, 2'b11, 16'h0007, 16'hC000);

    // 3: immediate select and zero A; shift code must not touch the immediate
    run_cmd("t3 neg", 3'd1, 3'd2, 2'b00, 1'b1, 1'b1, 5'b10110, 2'b10, 16'h0000, 16'hFFF6);
    run_cmd("t3 pos", 3'd1, 3'd2, 2'b11, 1'b0, 1'b1, 5'b01111, 2'b01, 16'h0007, 16'h000F);

    // 4: consumer stall holds operands
    bus.op_ready = 1'b0;
    issue_cmd(3'd2, 3'd1, 2'b01, 1'b0, 1'b0, 5'd0, 2'b11);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4 stall valid", {15'd0, bus.op_valid}, 16'd1);
      check("t4 stall Ain", bus.Ain, 16'h8001);
      check("t4 stall Bin", bus.Bin, 16'h000E);
      check("t4 stall ALUop", {14'd0, bus.ALUop}, 16'd3);
      check("t4 stall cmd_ready", {15'd0, bus.cmd_ready}, 16'd0);
      tick();
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check("t4 release valid", {15'd0, bus.op_valid}, 16'd0);
    check("t4 release cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);

    // 5: write in the LOAD_A cycle of the same index is bypassed into A
    bus.op_ready = 1'b1;
    issue_cmd(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00);
    bus.wb_en   = 1'b1;
    bus.wb_num  = 3'd1;
    bus.wb_data = 16'hBEEF;
    tick();
    bus.wb_en   = 1'b0;
    tick();
    check("t5 bypass valid", {15'd0, bus.op_valid}, 16'd1);
    check("t5 bypass Ain", bus.Ain, 16'hBEEF);
    check("t5 bypass Bin", bus.Bin, 16'h8001);
    tick();
    bus.op_ready = 1'b0;
    run_cmd("t5 stored", 3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01, 16'hBEEF, 16'hBEEF);

    // 6: reset during LOAD_B aborts the command and discards a same-cycle write
    issue_cmd(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10);
    tick();
    bus.wb_en   = 1'b1;
    bus.wb_num  = 3'd3;
    bus.wb_data = 16'h1234;
    rst_n = 1'b0;
    #1;
    check("t6 rst op_valid", {15'd0, bus.op_valid}, 16'd0);
    check("t6 rst Ain", bus.Ain, 16'h0000);
    check("t6 rst Bin", bus.Bin, 16'h0000);
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    rst_n = 1'b1;
    check("t6 cmd_ready after release", {15'd0, bus.cmd_ready}, 16'd1);
    run_cmd("t6 regs cleared", 3'd1, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
